// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR map, mstatus bits,
// mtvec modes, FSM states and the captured trap cause payload.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIP_EXT_BASE = 16;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Widest cause code is MIP_EXT_BASE + 15 = 31.
    localparam int unsigned CAUSE_CODE_W = 5;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ENTER = 1'b1
    } trap_state_t;

    typedef struct packed {
        logic                    intr;
        logic [CAUSE_CODE_W-1:0] code;
    } trap_cause_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trap_unit_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled interrupt lines.
module irq_prio_enc
    import trap_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] index
);

    always_comb begin
        valid = |req;
        index = '0;
        // Scan downward so the lowest set line is written last.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: exception and level interrupt entry, MRET
// handling and the associated CSR file, with optional vectored mtvec.
module trap_unit
    import trap_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     NUM_IRQ     = 4,
    parameter bit              VECTORED_EN = 1'b1,
    parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(32'h0000_0100)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               instr_boundary,
    input  logic [XLEN-1:0]    cur_pc,
    input  logic               exc_req,
    input  logic [3:0]         exc_cause,
    input  logic               mret,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               trap_take,
    output logic [XLEN-1:0]    trap_target,
    output logic [XLEN-1:0]    mepc_out,
    output logic               irq_pending
);

    localparam int unsigned IW = idx_width(NUM_IRQ);

    trap_state_t        state, state_next;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] mie_q;
    logic [NUM_IRQ-1:0] irq_active;
    logic               mstatus_mie, mstatus_mpie;
    logic [XLEN-3:0]    mtvec_base;
    logic               mtvec_vec;
    logic [XLEN-1:0]    mscratch_q, mepc_q, mcause_q;
    logic [XLEN-1:0]    cap_pc;
    trap_cause_t        cap_cause, cause_next;
    logic               capture;
    logic               enter;
    logic               enc_valid;
    logic [IW-1:0]      enc_index;
    logic [XLEN-1:0]    base_addr, vec_off;

    assign irq_active  = irq_q & mie_q;
    assign enter       = (state == ST_ENTER);
    assign irq_pending = |irq_active;
    assign mepc_out    = mepc_q;

    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio (
        .req   (irq_active),
        .valid (enc_valid),
        .index (enc_index)
    );

    // Trap FSM: exceptions outrank interrupts; ENTER always falls back to RUN.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        cause_next = cap_cause;
        case (state)
            ST_RUN: begin
                if (exc_req) begin
                    capture    = 1'b1;
                    cause_next = '{intr: 1'b0, code: CAUSE_CODE_W'(exc_cause)};
                    state_next = ST_ENTER;
                end else if (instr_boundary && mstatus_mie && enc_valid) begin
                    capture    = 1'b1;
                    cause_next = '{intr: 1'b1,
                                   code: CAUSE_CODE_W'(MIP_EXT_BASE) + CAUSE_CODE_W'(enc_index)};
                    state_next = ST_ENTER;
                end
            end
            ST_ENTER: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            trap_take <= 1'b0;
            cap_pc    <= '0;
            cap_cause <= '0;
        end else begin
            state     <= state_next;
            trap_take <= (state_next == ST_ENTER);
            if (capture) begin
                cap_pc    <= cur_pc;
                cap_cause <= cause_next;
            end
        end
    end

    // CSR file; trap entry owns mepc/mcause/mstatus during ENTER.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q        <= '0;
            mie_q        <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec_base   <= MTVEC_RESET[XLEN-1:2];
            mtvec_vec    <= VECTORED_EN && MTVEC_RESET[0];
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            irq_q <= irq;
            if (csr_we && csr_addr == CSR_MIE) begin
                mie_q <= csr_wdata[MIP_EXT_BASE +: NUM_IRQ];
            end
            if (csr_we && csr_addr == CSR_MTVEC) begin
                mtvec_base <= csr_wdata[XLEN-1:2];
                mtvec_vec  <= VECTORED_EN && csr_wdata[0];
            end
            if (csr_we && csr_addr == CSR_MSCRATCH) begin
                mscratch_q <= csr_wdata;
            end
            if (enter) begin
                mepc_q       <= cap_pc;
                mcause_q     <= {cap_cause.intr, {(XLEN-1-CAUSE_CODE_W){1'b0}}, cap_cause.code};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (csr_we && csr_addr == CSR_MEPC) begin
                    mepc_q <= {csr_wdata[XLEN-1:2], 2'b00};
                end
                if (csr_we && csr_addr == CSR_MCAUSE) begin
                    mcause_q <= csr_wdata;
                end
                if (mret && !capture) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end else if (csr_we && csr_addr == CSR_MSTATUS) begin
                    mstatus_mie  <= csr_wdata[MSTATUS_MIE];
                    mstatus_mpie <= csr_wdata[MSTATUS_MPIE];
                end
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mstatus_mie;
                csr_rdata[MSTATUS_MPIE] = mstatus_mpie;
            end
            CSR_MIE:      csr_rdata[MIP_EXT_BASE +: NUM_IRQ] = mie_q;
            CSR_MTVEC:    csr_rdata = {mtvec_base, 1'b0, mtvec_vec};
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MIP:      csr_rdata[MIP_EXT_BASE +: NUM_IRQ] = irq_q;
            default:      csr_rdata = '0;
        endcase
    end

    // Vectored offset applies to interrupts only; wrap is modulo 2^XLEN.
    assign base_addr   = {mtvec_base, 2'b00};
    assign vec_off     = XLEN'({cap_cause.code, 2'b00});
    assign trap_target = (mtvec_vec && cap_cause.intr) ? base_addr + vec_off : base_addr;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench: a vectored and a direct-only trap_unit share stimulus and
// are compared every cycle against a word-level model, plus directed literal checks.
module tb_trap_unit;
    import trap_pkg::*;

    localparam int unsigned NIRQ     = 4;
    localparam logic [31:0] MIE_MASK = ((32'h1 << NIRQ) - 32'h1) << 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            instr_boundary;
    logic [31:0]     cur_pc;
    logic            exc_req;
    logic [3:0]      exc_cause;
    logic            mret;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [31:0]     csr_wdata;

    logic [31:0] rdata0, rdata1, target0, target1, mepc0, mepc1;
    logic        take0, take1, pend0, pend1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    trap_unit #(.XLEN(32), .NUM_IRQ(NIRQ), .VECTORED_EN(1'b1), .MTVEC_RESET(32'h100)) u_vec (
        .clk(clk), .rst(rst), .irq(irq), .instr_boundary(instr_boundary), .cur_pc(cur_pc),
        .exc_req(exc_req), .exc_cause(exc_cause), .mret(mret), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata0), .trap_take(take0),
        .trap_target(target0), .mepc_out(mepc0), .irq_pending(pend0)
    );

    trap_unit #(.XLEN(32), .NUM_IRQ(NIRQ), .VECTORED_EN(1'b0), .MTVEC_RESET(32'h100)) u_dir (
        .clk(clk), .rst(rst), .irq(irq), .instr_boundary(instr_boundary), .cur_pc(cur_pc),
        .exc_req(exc_req), .exc_cause(exc_cause), .mret(mret), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(rdata1), .trap_take(take1),
        .trap_target(target1), .mepc_out(mepc1), .irq_pending(pend1)
    );

    // ---------------- reference model (word level) ----------------
    logic            m_mie_st, m_mpie, m_enter;
    logic [31:0]     m_mie, m_mscratch, m_mepc, m_mcause, m_cap_cause, m_cap_pc;
    logic [31:0]     m_mtvec[2];
    logic [NIRQ-1:0] m_irq;

    task automatic model_reset();
        m_mie_st = 0; m_mpie = 0; m_enter = 0;
        m_mie = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_cap_cause = 0; m_cap_pc = 0; m_irq = 0;
        m_mtvec[0] = 32'h100; m_mtvec[1] = 32'h100;
    endtask

    task automatic model_csr_write(input logic [11:0] a, input logic [31:0] w);
        case (a)
            CSR_MSTATUS:  begin m_mie_st = w[3]; m_mpie = w[7]; end
            CSR_MIE:      m_mie = w & MIE_MASK;
            CSR_MTVEC:    begin m_mtvec[0] = w & ~32'h2; m_mtvec[1] = w & ~32'h3; end
            CSR_MSCRATCH: m_mscratch = w;
            CSR_MEPC:     m_mepc = w & ~32'h3;
            CSR_MCAUSE:   m_mcause = w;
            default:      ;
        endcase
    endtask

    function automatic logic [31:0] m_mip();
        return 32'(m_irq) << 16;
    endfunction

    function automatic logic [31:0] m_rdata(input int i, input logic [11:0] a);
        case (a)
            CSR_MSTATUS:  return (m_mpie ? 32'h80 : 32'h0) | (m_mie_st ? 32'h8 : 32'h0);
            CSR_MIE:      return m_mie;
            CSR_MTVEC:    return m_mtvec[i];
            CSR_MSCRATCH: return m_mscratch;
            CSR_MEPC:     return m_mepc;
            CSR_MCAUSE:   return m_mcause;
            CSR_MIP:      return m_mip();
            default:      return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_target(input int i);
        logic [31:0] base;
        base = m_mtvec[i] & ~32'h3;
        if (m_mtvec[i][0] && m_cap_cause[31])
            return base + 32'd4 * (m_cap_cause & 32'h7fff_ffff);
        return base;
    endfunction

    task automatic model_step();
        logic        take;
        logic [31:0] cause, act;
        take  = 0;
        cause = 0;
        if (m_enter) begin
            m_mepc = m_cap_pc; m_mcause = m_cap_cause;
            m_mpie = m_mie_st; m_mie_st = 0; m_enter = 0;
            if (csr_we && !(csr_addr inside {CSR_MSTATUS, CSR_MEPC, CSR_MCAUSE}))
                model_csr_write(csr_addr, csr_wdata);
        end else begin
            act = m_mip() & m_mie;
            if (exc_req) begin
                take = 1; cause = 32'(exc_cause);
            end else if (instr_boundary && m_mie_st && act != 0) begin
                take = 1;
                for (int b = 31; b >= 16; b--)
                    if (act[b]) cause = 32'h8000_0000 + 32'(b);
            end
            if (csr_we) model_csr_write(csr_addr, csr_wdata);
            if (mret && !take) begin m_mie_st = m_mpie; m_mpie = 1; end
            if (take) begin m_enter = 1; m_cap_cause = cause; m_cap_pc = cur_pc; end
        end
        m_irq = irq;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("trap_take[%0d]", i), 32'(i == 0 ? take0 : take1), 32'(m_enter));
                check($sformatf("irq_pending[%0d]", i), 32'(i == 0 ? pend0 : pend1),
                      32'((m_mip() & m_mie) != 0));
                check($sformatf("mepc_out[%0d]", i), i == 0 ? mepc0 : mepc1, m_mepc);
                check($sformatf("csr_rdata[%0d] @%h", i, csr_addr), i == 0 ? rdata0 : rdata1,
                      m_rdata(i, csr_addr));
                if (m_enter)
                    check($sformatf("trap_target[%0d]", i), i == 0 ? target0 : target1, m_target(i));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] w);
        csr_we = 1; csr_addr = a; csr_wdata = w;
        tick();
        csr_we = 0;
    endtask

    task automatic read_chk(input string name, input logic [11:0] a,
                            input logic [31:0] e0, input logic [31:0] e1);
        csr_addr = a;
        @(negedge clk);
        #1;
        check({name, "_vec"}, rdata0, e0);
        check({name, "_dir"}, rdata1, e1);
        tick();
    endtask

    task automatic wait_take(input string name, input int max_cycles);
        bit seen;
        seen = 0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge clk);
            #1;
            if (take0) seen = 1;
            else tick();
        end
        if (!seen) check({name, "_timeout"}, 32'h0, 32'h1);
    endtask

    logic [11:0] addrs[8];

    initial begin
        addrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
                  CSR_MEPC, CSR_MCAUSE, CSR_MIP, 12'h7C0};
        rst = 0; irq = 0; instr_boundary = 0; cur_pc = 0; exc_req = 0; exc_cause = 0;
        mret = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1;
        chk_en = 1;
        tick();

        // Reset values
        check("reset_take", 32'(take0), 32'h0);
        check("reset_pending", 32'(pend0), 32'h0);
        read_chk("rst_mstatus", CSR_MSTATUS, 32'h0, 32'h0);
        read_chk("rst_mie", CSR_MIE, 32'h0, 32'h0);
        read_chk("rst_mtvec", CSR_MTVEC, 32'h100, 32'h100);
        read_chk("rst_mscratch", CSR_MSCRATCH, 32'h0, 32'h0);
        read_chk("rst_mepc", CSR_MEPC, 32'h0, 32'h0);
        read_chk("rst_mcause", CSR_MCAUSE, 32'h0, 32'h0);
        read_chk("rst_mip", CSR_MIP, 32'h0, 32'h0);
        read_chk("rst_unimpl", 12'h123, 32'h0, 32'h0);

        // Synchronous exception
        exc_req = 1; exc_cause = 4'd2; cur_pc = 32'h40;
        tick();
        exc_req = 0;
        @(negedge clk);
        #1;
        check("exc_take", 32'(take0), 32'h1);
        check("exc_target", target0, 32'h100);
        tick();
        check("exc_take_one_cycle", 32'(take0), 32'h0);
        check("exc_mepc", mepc0, 32'h40);
        read_chk("exc_mcause", CSR_MCAUSE, 32'h2, 32'h2);
        read_chk("exc_mstatus", CSR_MSTATUS, 32'h0, 32'h0);

        // Plain CSR behaviour
        csr_write(CSR_MSCRATCH, 32'hDEAD_BEEF);
        read_chk("mscratch", CSR_MSCRATCH, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        csr_write(CSR_MEPC, 32'h1237);
        read_chk("mepc_align", CSR_MEPC, 32'h1234, 32'h1234);

        // Vectored interrupt, lowest enabled line wins
        csr_write(CSR_MTVEC, 32'h201);
        csr_write(CSR_MIE, 32'hFFFF_FFFF);
        read_chk("mie_mask", CSR_MIE, 32'h000F_0000, 32'h000F_0000);
        csr_write(CSR_MSTATUS, 32'h8);
        irq = 4'b0110; instr_boundary = 1;
        wait_take("irq_take", 4);
        check("irq_target_vec", target0, 32'h244);
        check("irq_target_dir", target1, 32'h200);
        irq = 0; instr_boundary = 0;
        tick();
        read_chk("irq_mcause", CSR_MCAUSE, 32'h8000_0011, 32'h8000_0011);
        read_chk("irq_mstatus", CSR_MSTATUS, 32'h80, 32'h80);

        // Masked by MIE, then released by mret
        irq = 4'b0110; instr_boundary = 1;
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("masked_no_take", 32'(take0), 32'h0);
        check("masked_pending", 32'(pend0), 32'h1);
        tick();
        mret = 1;
        tick();
        mret = 0;
        wait_take("mret_irq_take", 3);
        check("mret_irq_target", target0, 32'h244);
        irq = 0; instr_boundary = 0;
        tick();
        read_chk("mret_mstatus", CSR_MSTATUS, 32'h80, 32'h80);

        // Exception beats interrupt; trap entry beats a same-cycle mepc write
        csr_write(CSR_MSTATUS, 32'h8);
        irq = 4'b0001;
        tick();
        exc_req = 1; exc_cause = 4'd5; cur_pc = 32'h80; instr_boundary = 1;
        tick();
        exc_req = 0; instr_boundary = 0;
        csr_we = 1; csr_addr = CSR_MEPC; csr_wdata = 32'h1234;
        @(negedge clk);
        #1;
        check("both_take", 32'(take0), 32'h1);
        check("both_target", target0, 32'h200);
        tick();
        csr_we = 0;
        check("both_mepc", mepc0, 32'h80);
        read_chk("both_mcause", CSR_MCAUSE, 32'h5, 32'h5);
        csr_write(CSR_MSTATUS, 32'h8);
        instr_boundary = 1;
        wait_take("deferred_take", 4);
        check("deferred_target_vec", target0, 32'h240);
        check("deferred_target_dir", target1, 32'h200);
        irq = 0; instr_boundary = 0;
        tick();
        read_chk("deferred_mcause", CSR_MCAUSE, 32'h8000_0010, 32'h8000_0010);

        // Mode bit 1 forced low; vectored mode only where enabled
        csr_write(CSR_MTVEC, 32'h303);
        read_chk("mtvec_303", CSR_MTVEC, 32'h301, 32'h300);
        csr_write(CSR_MSTATUS, 32'h8);
        irq = 4'b0001; instr_boundary = 1;
        wait_take("mode_take", 4);
        check("mode_target_vec", target0, 32'h340);
        check("mode_target_dir", target1, 32'h300);
        irq = 0; instr_boundary = 0;
        tick();

        // Reset in the middle of ENTER
        exc_req = 1; exc_cause = 4'd3; cur_pc = 32'h98;
        tick();
        exc_req = 0;
        #2 rst = 0;
        #1;
        check("rst_enter_take", 32'(take0), 32'h0);
        check("rst_enter_mepc", mepc0, 32'h0);
        @(negedge clk);
        #1 rst = 1;
        tick();
        read_chk("rst_enter_mtvec", CSR_MTVEC, 32'h100, 32'h100);
        read_chk("rst_enter_mcause", CSR_MCAUSE, 32'h0, 32'h0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) irq = NIRQ'($urandom);
            instr_boundary = 1'($urandom_range(0, 1));
            exc_req        = ($urandom_range(0, 15) == 0);
            exc_cause      = 4'($urandom);
            cur_pc         = $urandom;
            mret           = ($urandom_range(0, 15) == 0);
            csr_we         = ($urandom_range(0, 4) == 0);
            csr_addr       = addrs[$urandom_range(0, 7)];
            csr_wdata      = $urandom;
            if (csr_we && csr_addr == CSR_MSTATUS) mret = 0;
            tick();
        end
        exc_req = 0; mret = 0; csr_we = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
